// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
// Drives the 2-bit select of the downstream 4:1 channel mux. It steps `sel`
// through the enabled channels in ascending round-robin order and holds each
// channel for a programmable dwell. A run covers a fixed number of sweeps, or
// runs continuously when sweeps == 0.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   level-sampled run request (acted on in IDLE only)
//   stop       in   abort; beats start, dwell expiry and sweep completion
//   ch_en      in   [3:0] channel enable mask, bit i = mux input i
//   dwell      in   [DWELL_W-1:0] cycles per channel (0 acts as 1)
//   sweeps     in   [SWEEP_W-1:0] sweeps per run (0 = continuous)
//   sel        out  [1:0] registered mux select
//   sel_valid  out  sel is an active, sequenced selection
//   busy       out  high in RUN
//   done       out  one-cycle pulse when a finite run completes
//   err        out  one-cycle pulse on start with an empty channel mask
//
// State  | meaning
// IDLE   | waiting for start; sel holds its last value
// RUN    | sequencing channels; sel_valid and busy high
// DONE   | single cycle after the final sweep; done pulses, start ignored

module mux_sel_sequencer #(
   parameter int DWELL_W = 8,
   parameter int SWEEP_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [3:0]         ch_en,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [SWEEP_W-1:0] sweeps,
   output logic [1:0]         sel,
   output logic               sel_valid,
   output logic               busy,
   output logic               done,
   output logic               err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         ch_en_q, ch_en_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [SWEEP_W-1:0] sweeps_q, sweeps_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [SWEEP_W-1:0] sweep_cnt_q, sweep_cnt_d;
   logic [1:0]         sel_q, sel_d;
   logic               sel_valid_q, sel_valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               err_q, err_d;

   logic [1:0]         start_low;
   logic [1:0]         wrap_low;
   logic [1:0]         nxt_ch;
   logic               nxt_found;
   logic [DWELL_W-1:0] dwell_last;
   logic [SWEEP_W-1:0] sweep_inc;
   logic               expiry;

   // A latched dwell of 0 behaves as 1, so the last count is 0 in both cases.
   assign dwell_last = (dwell_q == '0) ? '0 : dwell_q - 1'b1;
   assign expiry     = (cnt_q == dwell_last);
   assign sweep_inc  = sweep_cnt_q + 1'b1;

   // Lowest enabled channel: of the live mask for a start, of the latched mask
   // for a wrap. Descending loops leave the lowest match as the final value.
   always_comb begin
      start_low = 2'd0;
      wrap_low  = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (ch_en[i])   start_low = 2'(i);
         if (ch_en_q[i]) wrap_low  = 2'(i);
      end
   end

   // Nearest enabled channel above the current selection, if any.
   always_comb begin
      nxt_ch    = 2'd0;
      nxt_found = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (ch_en_q[i] && (i > int'(sel_q))) begin
            nxt_ch    = 2'(i);
            nxt_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ch_en_d     = ch_en_q;
      dwell_d     = dwell_q;
      sweeps_d    = sweeps_q;
      cnt_d       = cnt_q;
      sweep_cnt_d = sweep_cnt_q;
      sel_d       = sel_q;
      sel_valid_d = sel_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start && !stop) begin
               if (ch_en == 4'b0000) begin
                  err_d = 1'b1;
               end else begin
                  state_d     = ST_RUN;
                  ch_en_d     = ch_en;
                  dwell_d     = dwell;
                  sweeps_d    = sweeps;
                  cnt_d       = '0;
                  sweep_cnt_d = '0;
                  sel_d       = start_low;
                  sel_valid_d = 1'b1;
                  busy_d      = 1'b1;
               end
            end
         end

         ST_RUN: begin
            if (stop) begin
               state_d     = ST_IDLE;
               sel_valid_d = 1'b0;
               busy_d      = 1'b0;
            end else if (expiry) begin
               cnt_d = '0;
               if (nxt_found) begin
                  sel_d = nxt_ch;
               end else if ((sweeps_q != '0) && (sweep_inc == sweeps_q)) begin
                  // Final sweep: sel keeps the last channel for the mux.
                  state_d     = ST_DONE;
                  sel_valid_d = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  sel_d = wrap_low;
                  // Continuous runs saturate rather than roll over.
                  if (sweep_cnt_q != '1) sweep_cnt_d = sweep_inc;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d     = ST_IDLE;
            sel_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ch_en_q     <= '0;
         dwell_q     <= '0;
         sweeps_q    <= '0;
         cnt_q       <= '0;
         sweep_cnt_q <= '0;
         sel_q       <= 2'd0;
         sel_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_en_q     <= ch_en_d;
         dwell_q     <= dwell_d;
         sweeps_q    <= sweeps_d;
         cnt_q       <= cnt_d;
         sweep_cnt_q <= sweep_cnt_d;
         sel_q       <= sel_d;
         sel_valid_q <= sel_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign sel       = sel_q;
   assign sel_valid = sel_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
